// File: rtl/intr_ctrl_if.sv
// intr_ctrl_if: processor-side bus for the interrupt controller.
//
// Signals:
//   ABUS  bus address
//   RE    read enable (a register is read combinationally while RE=1)
//   WBUS  write data
//   WE    write enable (a write takes effect on the next qualified CLK edge)
//
// The read-data bus RBUS is a shared tri-state net, so it is a plain inout
// port on the controller rather than part of this interface.
//
// Modports:
//   master  drives the bus (processor or testbench)
//   slave   observes the bus (intr_ctrl)
interface intr_ctrl_if #(
    parameter int ABITS = 16,
    parameter int DBITS = 16
);
    logic [ABITS-1:0] ABUS;
    logic             RE;
    logic [DBITS-1:0] WBUS;
    logic             WE;

    modport master (output ABUS, output RE, output WBUS, output WE);
    modport slave  (input  ABUS, input  RE, input  WBUS, input  WE);
endinterface

// File: rtl/intr_ctrl.sv
// intr_ctrl: memory-mapped interrupt controller.
//
// The controller latches rising edges of IRQ into pending bits and applies a
// per-source enable mask. It raises INTR toward the processor, and it provides
// a fixed-priority vector register in which index 0 has the highest priority.
// A read of VEC acknowledges the interrupt, and a write to VEC is the EOI.
//
// Ports:
//   CLK        system clock; all state changes on posedge, gated by LOCK
//   INIT       synchronous active-high reset (effective only when LOCK=1)
//   LOCK       clock-valid qualifier; LOCK=0 freezes every register
//   bus        address / write data / RE / WE (intr_ctrl_if.slave)
//   RBUS       read data, driven only while one of our registers is read
//   IRQ        level interrupt requests from devices
//   INTR       interrupt request to the processor
//   dbg_insvc  current FSM state (1 = INSVC, 0 = IDLE)
//
// Register map (offsets from RBASE):
//   +0 PEND  read pending; writing 0 to a bit clears it, writing 1 is ignored
//   +2 MASK  per-source enable
//   +4 VEC   read = acknowledge vector, any write = EOI
//   +6 CTRL  bit4 GIE (rw), bit0 INSVC (ro)
//
// NIRQ must be in 1..16. DBITS must be >= NIRQ and >= 5.
module intr_ctrl #(
    parameter int               ABITS = 16,
    parameter int               DBITS = 16,
    parameter logic [ABITS-1:0] RBASE = ABITS'(16'hF800),
    parameter int               NIRQ  = 4
) (
    input  logic             CLK,
    input  logic             INIT,
    input  logic             LOCK,
    intr_ctrl_if.slave       bus,
    inout  wire  [DBITS-1:0] RBUS,
    input  logic [NIRQ-1:0]  IRQ,
    output logic             INTR,
    output logic             dbg_insvc
);

    typedef enum logic {IDLE = 1'b0, INSVC = 1'b1} state_t;

    state_t            state, state_nx;
    logic [NIRQ-1:0]   pend, mask, prev;
    logic              gie;
    logic [3:0]        cur;

    // Address decode
    logic sel_pend, sel_mask, sel_vec, sel_ctrl, hit;
    assign sel_pend = (bus.ABUS == RBASE);
    assign sel_mask = (bus.ABUS == RBASE + ABITS'(2));
    assign sel_vec  = (bus.ABUS == RBASE + ABITS'(4));
    assign sel_ctrl = (bus.ABUS == RBASE + ABITS'(6));
    assign hit      = sel_pend | sel_mask | sel_vec | sel_ctrl;

    logic vec_rd, vec_wr;
    assign vec_rd = bus.RE & sel_vec;
    assign vec_wr = bus.WE & sel_vec;

    // Only the low NIRQ bits and GIE (bit 4) of the write data are meaningful.
    logic unused_wbus;
    assign unused_wbus = ^bus.WBUS;

    // Fixed-priority candidate: the lowest enabled pending index.
    logic [NIRQ-1:0] active;
    logic [3:0]      cand;
    logic            valid;
    assign active = pend & mask;
    assign valid  = |active;

    always_comb begin
        cand = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (active[i]) cand = 4'(i);
        end
    end

    // FSM: state register
    always_ff @(posedge CLK) begin
        if (LOCK) begin
            if (INIT) state <= IDLE;
            else      state <= state_nx;
        end
    end

    // FSM: next state
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (vec_rd && valid) state_nx = INSVC;
            INSVC:   if (vec_wr)          state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // FSM: outputs
    logic ack;
    always_comb begin
        ack       = (state == IDLE) && vec_rd && valid;
        INTR      = gie && (state == IDLE) && valid;
        dbg_insvc = (state == INSVC);
    end

    // Bits to clear this cycle. New rising edges are OR-ed in after the clear,
    // so a set in the same cycle as a clear wins.
    logic [NIRQ-1:0] rise, clr;
    assign rise = IRQ & ~prev;

    always_comb begin
        clr = '0;
        if (bus.WE && sel_pend) clr = ~bus.WBUS[NIRQ-1:0];
        if (ack)                clr = clr | (NIRQ'(1) << cand);
    end

    always_ff @(posedge CLK) begin
        if (LOCK) begin
            // prev follows IRQ even during reset, so lines that are already
            // high when reset is released do not count as edges.
            prev <= IRQ;
            if (INIT) begin
                pend <= '0;
                mask <= '0;
                gie  <= 1'b0;
                cur  <= '0;
            end else begin
                pend <= (pend & ~clr) | rise;
                if (bus.WE && sel_mask) mask <= bus.WBUS[NIRQ-1:0];
                if (bus.WE && sel_ctrl) gie  <= bus.WBUS[4];
                if (ack)                cur  <= cand;
            end
        end
    end

    // Combinational read mux
    logic [DBITS-1:0] rdata;
    always_comb begin
        rdata = '0;
        if (sel_pend) rdata = DBITS'(pend);
        if (sel_mask) rdata = DBITS'(mask);
        if (sel_vec) begin
            if (state == INSVC) rdata = DBITS'(cur);
            else if (valid)     rdata = DBITS'(cand);
            else                rdata = '1;
        end
        if (sel_ctrl) begin
            rdata[4] = gie;
            rdata[0] = (state == INSVC);
        end
    end

    assign RBUS = (bus.RE && hit) ? rdata : {DBITS{1'bz}};

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl. Inputs change 1 ns after a rising edge, and
// combinational outputs are sampled 1 ns later, well away from the edge.
module tb_intr_ctrl;

    localparam logic [15:0] A_PEND = 16'hF800;
    localparam logic [15:0] A_MASK = 16'hF802;
    localparam logic [15:0] A_VEC  = 16'hF804;
    localparam logic [15:0] A_CTRL = 16'hF806;

    logic        clk = 1'b0;
    logic        init;
    logic        lock;
    logic [3:0]  irq;
    logic        intr;
    logic        dbg_insvc;
    wire  [15:0] rbus;

    int n_cmp = 0;
    int n_err = 0;

    intr_ctrl_if #(.ABITS(16), .DBITS(16)) bus ();

    intr_ctrl #(.ABITS(16), .DBITS(16), .RBASE(16'hF800), .NIRQ(4)) dut (
        .CLK       (clk),
        .INIT      (init),
        .LOCK      (lock),
        .bus       (bus),
        .RBUS      (rbus),
        .IRQ       (irq),
        .INTR      (intr),
        .dbg_insvc (dbg_insvc)
    );

    // Clock and reset
    always #5 clk = ~clk;

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [15:0] addr, input logic [15:0] exp, input string tag);
        bus.ABUS = addr;
        bus.RE   = 1'b1;
        #1;
        check(tag, rbus, exp);
        tick();
        bus.RE = 1'b0;
    endtask

    task automatic wr(input logic [15:0] addr, input logic [15:0] data);
        bus.ABUS = addr;
        bus.WBUS = data;
        bus.WE   = 1'b1;
        tick();
        bus.WE = 1'b0;
    endtask

    task automatic chk_intr(input logic exp, input string tag);
        #1;
        check(tag, {15'd0, intr}, {15'd0, exp});
    endtask

    task automatic pulse(input logic [3:0] v);
        irq = v;
        tick();
        irq = 4'b0000;
    endtask

    initial begin
        bus.ABUS = 16'h0000;
        bus.RE   = 1'b0;
        bus.WBUS = 16'h0000;
        bus.WE   = 1'b0;
        init = 1'b1;
        lock = 1'b1;
        irq  = 4'b0010;
        tick();
        tick();
        init = 1'b0;

        // Reset with IRQ[1] already high: no pending bit
        chk_intr(1'b0, "reset_intr");
        check("reset_state", {15'd0, dbg_insvc}, 16'h0000);
        rd(A_PEND, 16'h0000, "reset_pend");
        wr(A_MASK, 16'h000F);
        wr(A_CTRL, 16'h0010);
        rd(A_MASK, 16'h000F, "mask_rw");
        rd(A_CTRL, 16'h0010, "ctrl_gie");
        rd(A_PEND, 16'h0000, "held_line_no_edge");
        chk_intr(1'b0, "held_line_intr");
        irq = 4'b0000;
        tick();
        irq = 4'b0010;
        tick();
        rd(A_PEND, 16'h0002, "reedge_pend");
        chk_intr(1'b1, "reedge_intr");
        rd(A_VEC, 16'h0001, "reedge_vec");
        wr(A_VEC, 16'h0000);
        irq = 4'b0000;
        tick();
        chk_intr(1'b0, "after_eoi1_intr");

        // Two simultaneous sources: priority picks index 1, then index 3
        pulse(4'b1010);
        rd(A_VEC, 16'h0001, "prio_vec1");
        rd(A_CTRL, 16'h0011, "prio_ctrl_insvc");
        chk_intr(1'b0, "prio_insvc_intr");
        rd(A_PEND, 16'h0008, "prio_pend");
        wr(A_VEC, 16'h0000);
        chk_intr(1'b1, "prio_eoi_intr");
        rd(A_VEC, 16'h0003, "prio_vec3");
        wr(A_VEC, 16'h0000);
        chk_intr(1'b0, "prio_done_intr");

        // Masked source: spurious vector, no state change
        wr(A_MASK, 16'h0004);
        pulse(4'b0001);
        chk_intr(1'b0, "masked_intr");
        rd(A_VEC, 16'hFFFF, "masked_vec");
        rd(A_CTRL, 16'h0010, "masked_ctrl");
        wr(A_MASK, 16'h0005);
        chk_intr(1'b1, "unmask_intr");
        rd(A_VEC, 16'h0000, "unmask_vec");
        wr(A_VEC, 16'h0000);
        wr(A_VEC, 16'h0000); // write in IDLE is ignored
        rd(A_CTRL, 16'h0010, "idle_eoi_ignored");

        // Repeated acknowledge in INSVC; new edge latched but not signalled
        pulse(4'b0100);
        rd(A_VEC, 16'h0002, "insvc_vec_a");
        rd(A_VEC, 16'h0002, "insvc_vec_b");
        rd(A_CTRL, 16'h0011, "insvc_ctrl");
        pulse(4'b0001);
        rd(A_PEND, 16'h0001, "insvc_new_pend");
        chk_intr(1'b0, "insvc_no_nest");
        wr(A_VEC, 16'h0000);
        chk_intr(1'b1, "insvc_eoi_intr");
        rd(A_VEC, 16'h0000, "insvc_next_vec");
        wr(A_VEC, 16'h0000);

        // PEND write clears only zero bits; a set wins over a same-cycle clear
        pulse(4'b1010);
        chk_intr(1'b0, "pend_masked_intr");
        rd(A_PEND, 16'h000A, "pend_before");
        wr(A_PEND, 16'h0007);
        rd(A_PEND, 16'h0002, "pend_w0_clear");
        irq = 4'b0010;
        wr(A_PEND, 16'h0000);
        irq = 4'b0000;
        rd(A_PEND, 16'h0002, "pend_set_wins");

        // LOCK=0 freezes state, but reads still work
        lock = 1'b0;
        irq  = 4'b0100;
        tick();
        irq  = 4'b0000;
        tick();
        wr(A_MASK, 16'h000F);
        rd(A_PEND, 16'h0002, "lock_read_pend");
        rd(A_MASK, 16'h0005, "lock_mask_frozen");
        lock = 1'b1;
        tick();
        rd(A_PEND, 16'h0002, "lock_released_pend");

        // INIT while INSVC clears everything
        wr(A_MASK, 16'h000F);
        chk_intr(1'b1, "pre_init_intr");
        rd(A_VEC, 16'h0001, "pre_init_vec");
        pulse(4'b1000);
        rd(A_CTRL, 16'h0011, "pre_init_ctrl");
        init = 1'b1;
        tick();
        init = 1'b0;
        rd(A_CTRL, 16'h0000, "init_ctrl");
        rd(A_MASK, 16'h0000, "init_mask");
        rd(A_PEND, 16'h0000, "init_pend");
        chk_intr(1'b0, "init_intr");
        check("init_state", {15'd0, dbg_insvc}, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Safety net against a hung run
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
